// File: rtl/axi_lite_ram_if.sv
// AXI-lite manager/subordinate signal bundle shared by the core ports and axi_lite_ram.
// The read response is named resp (not rresp) to match the core's port naming.
interface axi_lite_if #(
  parameter int ALEN = 64,
  parameter int DLEN = 64
);
  logic              awvalid;
  logic              awready;
  logic [ALEN-1:0]   awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DLEN-1:0]   wdata;
  logic [DLEN/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ALEN-1:0]   araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DLEN-1:0]   rdata;
  logic [1:0]        resp;

  modport S (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, resp
  );

  modport M (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, resp
  );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI-lite subordinate word RAM with byte-strobed writes, one outstanding transaction per channel.
// Optional macro AXIL_RAM_RANGE_CHECK_EN: out-of-range accesses get SLVERR instead of wrapping.
module axi_lite_ram #(
  parameter int    ALEN      = 64,
  parameter int    DLEN      = 64,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input logic   clk,
  input logic   rst,
  axi_lite_if.S s
);
  localparam int STRB_W = DLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TOP_W  = OFF_W + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_RAM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  logic [DLEN-1:0] mem [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ALEN-1:0] addr);
    return addr[TOP_W-1:OFF_W];
  endfunction

  // Without range checking the upper address bits simply alias onto the array.
  function automatic logic addr_ok(input logic [ALEN-1:0] addr);
    return !RANGE_CHECK || (addr[ALEN-1:TOP_W] == '0);
  endfunction

  // ---------------------------------------------------------------- read channel
  r_state_t r_state;
  logic     ar_hs;

  assign ar_hs = s.arvalid && s.arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      s.arready <= 1'b1;
      s.rvalid  <= 1'b0;
      s.resp    <= RESP_OKAY;
      s.rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state   <= R_RESP;
            s.arready <= 1'b0;
            s.rvalid  <= 1'b1;
            if (addr_ok(s.araddr)) begin
              s.rdata <= mem[word_idx(s.araddr)];
              s.resp  <= RESP_OKAY;
            end else begin
              s.rdata <= '0;
              s.resp  <= RESP_SLVERR;
            end
          end
        end
        R_RESP: begin
          if (s.rready) begin
            r_state   <= R_IDLE;
            s.rvalid  <= 1'b0;
            s.arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- write channel
  w_state_t          w_state;
  logic              aw_held;
  logic              w_held;
  logic [ALEN-1:0]   awaddr_q;
  logic [DLEN-1:0]   wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic [ALEN-1:0]   cm_addr;
  logic [DLEN-1:0]   cm_data;
  logic [STRB_W-1:0] cm_strb;

  // The later of AW/W commits on its own handshake edge, using the live bus value
  // for that channel, so bvalid follows the later handshake by exactly one cycle.
  always_comb begin
    aw_hs   = s.awvalid && s.awready;
    w_hs    = s.wvalid && s.wready;
    commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs) && !rst;
    cm_addr = aw_held ? awaddr_q : s.awaddr;
    cm_data = w_held ? wdata_q : s.wdata;
    cm_strb = w_held ? wstrb_q : s.wstrb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      s.awready <= 1'b1;
      s.wready  <= 1'b1;
      s.bvalid  <= 1'b0;
      s.bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            w_state   <= W_RESP;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b1;
            s.bresp   <= addr_ok(cm_addr) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              s.awready <= 1'b0;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              s.wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s.bready) begin
            w_state   <= W_IDLE;
            s.bvalid  <= 1'b0;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= s.awaddr;
    if (w_hs) begin
      wdata_q <= s.wdata;
      wstrb_q <= s.wstrb;
    end
  end

  // Same-edge read capture above sees the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (commit && addr_ok(cm_addr)) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (cm_strb[k]) mem[word_idx(cm_addr)][8*k +: 8] <= cm_data[8*k +: 8];
      end
    end
  end

  logic unused;
  assign unused = ^{s.awprot, s.arprot, s.araddr[OFF_W-1:0], cm_addr[OFF_W-1:0]};

endmodule
